wb_ddr3_arbiter: RTL and testbench

WB_DDR3_ARBITER -- requirements
Module: wb_ddr3_arbiter

---
 rtl/wb_ddr3_arbiter.sv | 176 +++++++++++++++++
 tb/tb_wb_ddr3_arbiter.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/wb_ddr3_arbiter.sv
// Two-requester Wishbone arbiter in front of a DDR3 controller port, with an outstanding-request limit.
// Optional burst hand-over after MAX_BURST strobes is compiled in with WB_ARB_BURST_LIMIT_EN.
module wb_ddr3_arbiter #(
    parameter int unsigned ADDR_BITS       = 24,
    parameter int unsigned DATA_BITS       = 128,
    parameter int unsigned SEL_BITS        = 16,
    parameter int unsigned MAX_OUTSTANDING = 8,
    parameter int unsigned MAX_BURST       = 16
) (
    input  logic                   i_controller_clk,
    input  logic                   i_rst_n,
    input  logic [1:0]             i_s_cyc,
    input  logic [1:0]             i_s_stb,
    input  logic [1:0]             i_s_we,
    input  logic [2*ADDR_BITS-1:0] i_s_addr,
    input  logic [2*DATA_BITS-1:0] i_s_data,
    input  logic [2*SEL_BITS-1:0]  i_s_sel,
    output logic [1:0]             o_s_stall,
    output logic [1:0]             o_s_ack,
    output logic [DATA_BITS-1:0]   o_s_data,
    output logic                   o_m_cyc,
    output logic                   o_m_stb,
    output logic                   o_m_we,
    output logic [ADDR_BITS-1:0]   o_m_addr,
    output logic [DATA_BITS-1:0]   o_m_data,
    output logic [SEL_BITS-1:0]    o_m_sel,
    input  logic                   i_m_stall,
    input  logic                   i_m_ack,
    input  logic [DATA_BITS-1:0]   i_m_data
);

    localparam int unsigned CNT_W = 8;
    localparam logic [CNT_W-1:0] MAX_OUT = CNT_W'(MAX_OUTSTANDING);

    if (MAX_OUTSTANDING < 1 || MAX_OUTSTANDING > 255) begin : g_bad_max_outstanding
        $error("MAX_OUTSTANDING must be 1..255");
    end
    if (MAX_BURST < 1 || MAX_BURST > 255) begin : g_bad_max_burst
        $error("MAX_BURST must be 1..255");
    end

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_OWN   = 2'd1,
        S_DRAIN = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic             owner_q, owner_d;
    logic             last_q, last_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic own_cyc;
    logic own_stb;
    logic limit_stall;
    logic ack_ok;
    logic inc;
    logic dec;

`ifdef WB_ARB_BURST_LIMIT_EN
    localparam logic [CNT_W-1:0] MAX_BURST_L = CNT_W'(MAX_BURST);
    logic [CNT_W-1:0] burst_q, burst_d;
    logic             oth_cyc;
`endif

    // Master-side payload always follows the current owner.
    assign o_m_we   = i_s_we[owner_q];
    assign o_m_addr = owner_q ? i_s_addr[ADDR_BITS +: ADDR_BITS] : i_s_addr[0 +: ADDR_BITS];
    assign o_m_data = owner_q ? i_s_data[DATA_BITS +: DATA_BITS] : i_s_data[0 +: DATA_BITS];
    assign o_m_sel  = owner_q ? i_s_sel[SEL_BITS +: SEL_BITS] : i_s_sel[0 +: SEL_BITS];
    assign o_s_data = i_m_data;

    // State, ownership and outstanding-count bookkeeping.
    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        last_d    = last_q;
        cnt_d     = cnt_q;
        o_s_stall = 2'b11;
        o_s_ack   = 2'b00;
        o_m_cyc   = 1'b0;
        o_m_stb   = 1'b0;
        inc       = 1'b0;
        dec       = 1'b0;
        own_cyc   = i_s_cyc[owner_q];
        own_stb   = i_s_stb[owner_q];
        // An ack in the same cycle frees a slot, so it lifts the limit immediately.
        limit_stall = (cnt_q == MAX_OUT) && !i_m_ack;
        ack_ok      = i_m_ack && (cnt_q != '0);
`ifdef WB_ARB_BURST_LIMIT_EN
        burst_d = burst_q;
        oth_cyc = i_s_cyc[~owner_q];
`endif

        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (|i_s_cyc) begin
                    state_d = S_OWN;
                    owner_d = (&i_s_cyc) ? ~last_q : i_s_cyc[1];
                    last_d  = owner_d;
`ifdef WB_ARB_BURST_LIMIT_EN
                    burst_d = '0;
`endif
                end
            end

            S_OWN: begin
                o_m_cyc = own_cyc;
                if (own_cyc) begin
                    o_m_stb            = own_stb && !limit_stall;
                    o_s_stall[owner_q] = i_m_stall || limit_stall;
                    o_s_ack[owner_q]   = ack_ok;
                    inc                = o_m_stb && !i_m_stall;
                    dec                = ack_ok;
                    cnt_d              = cnt_q + CNT_W'(inc) - CNT_W'(dec);
`ifdef WB_ARB_BURST_LIMIT_EN
                    burst_d = (burst_q >= MAX_BURST_L) ? MAX_BURST_L : burst_q + CNT_W'(inc);
                    if ((burst_d == MAX_BURST_L) && oth_cyc) begin
                        state_d = S_DRAIN;
                    end
`endif
                end else begin
                    // Owner abandoned the cycle: drop everything still in flight.
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end
            end

            S_DRAIN: begin
                o_m_cyc = own_cyc;
                if (own_cyc) begin
                    o_s_ack[owner_q] = ack_ok;
                    dec              = ack_ok;
                    cnt_d            = cnt_q - CNT_W'(dec);
                    if (cnt_d == '0) begin
                        state_d = S_IDLE;
                    end
                end else begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end
            end

            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge i_controller_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= S_IDLE;
            owner_q <= 1'b0;
            last_q  <= 1'b1;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
        end
    end

`ifdef WB_ARB_BURST_LIMIT_EN
    always_ff @(posedge i_controller_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            burst_q <= '0;
        end else begin
            burst_q <= burst_d;
        end
    end
`endif

endmodule

// File: tb/tb_wb_ddr3_arbiter.sv
// Directed, table-driven bench for wb_ddr3_arbiter (MAX_OUTSTANDING=2, MAX_BURST=4).
module tb_wb_ddr3_arbiter;

    localparam int unsigned AW = 24;
    localparam int unsigned DW = 128;
    localparam int unsigned SW = 16;

    localparam logic [AW-1:0] A0 = 24'h000010;
    localparam logic [AW-1:0] A1 = 24'h000020;
    localparam logic [DW-1:0] D0 = 128'h0123_4567_89AB_CDEF_0011_2233_4455_6677;
    localparam logic [DW-1:0] D1 = 128'hFEDC_BA98_7654_3210_8899_AABB_CCDD_EEFF;
    localparam logic [SW-1:0] S0 = 16'h00FF;
    localparam logic [SW-1:0] S1 = 16'hFF00;
    localparam logic [DW-1:0] MD = 128'hA5;

    logic            clk;
    logic            rst_n;
    logic [1:0]      s_cyc, s_stb, s_we;
    logic [2*AW-1:0] s_addr;
    logic [2*DW-1:0] s_data;
    logic [2*SW-1:0] s_sel;
    logic [1:0]      s_stall, s_ack;
    logic [DW-1:0]   s_rdata;
    logic            m_cyc, m_stb, m_we;
    logic [AW-1:0]   m_addr;
    logic [DW-1:0]   m_data;
    logic [SW-1:0]   m_sel;
    logic            m_stall, m_ack;
    logic [DW-1:0]   m_rdata;

    int checks = 0;
    int errors = 0;

    wb_ddr3_arbiter #(
        .ADDR_BITS(AW), .DATA_BITS(DW), .SEL_BITS(SW),
        .MAX_OUTSTANDING(2), .MAX_BURST(4)
    ) dut (
        .i_controller_clk(clk),
        .i_rst_n(rst_n),
        .i_s_cyc(s_cyc),
        .i_s_stb(s_stb),
        .i_s_we(s_we),
        .i_s_addr(s_addr),
        .i_s_data(s_data),
        .i_s_sel(s_sel),
        .o_s_stall(s_stall),
        .o_s_ack(s_ack),
        .o_s_data(s_rdata),
        .o_m_cyc(m_cyc),
        .o_m_stb(m_stb),
        .o_m_we(m_we),
        .o_m_addr(m_addr),
        .o_m_data(m_data),
        .o_m_sel(m_sel),
        .i_m_stall(m_stall),
        .i_m_ack(m_ack),
        .i_m_data(m_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic          rst_n;
        logic [1:0]    cyc, stb, we;
        logic          m_stall, m_ack;
        logic [1:0]    e_stall, e_ack;
        logic          e_mcyc, e_mstb, e_we;
        logic [AW-1:0] e_addr;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic r, input logic [1:0] cyc, input logic [1:0] stb,
                                input logic [1:0] we, input logic ms, input logic ma,
                                input logic [1:0] es, input logic [1:0] ea, input logic emc,
                                input logic ems, input logic ewe, input logic [AW-1:0] eaddr);
        vec_t v;
        v.rst_n = r;   v.cyc = cyc;  v.stb = stb;   v.we = we;
        v.m_stall = ms; v.m_ack = ma;
        v.e_stall = es; v.e_ack = ea; v.e_mcyc = emc; v.e_mstb = ems; v.e_we = ewe;
        v.e_addr = eaddr;
        return v;
    endfunction

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    initial begin
        rst_n   = 1'b0;
        s_cyc   = 2'b00;
        s_stb   = 2'b00;
        s_we    = 2'b00;
        s_addr  = {A1, A0};
        s_data  = {D1, D0};
        s_sel   = {S1, S0};
        m_stall = 1'b0;
        m_ack   = 1'b0;
        m_rdata = MD;

        // Reset, then requester 0 writes and reads 0x10
        vecs.push_back(mk(0, 2'b00, 2'b00, 2'b00, 0, 0, 2'b11, 2'b00, 0, 0, 0, A0));
        vecs.push_back(mk(1, 2'b00, 2'b00, 2'b00, 0, 0, 2'b11, 2'b00, 0, 0, 0, A0));
        vecs.push_back(mk(1, 2'b01, 2'b01, 2'b01, 0, 0, 2'b11, 2'b00, 0, 0, 0, A0));
        vecs.push_back(mk(1, 2'b01, 2'b01, 2'b01, 0, 0, 2'b10, 2'b00, 1, 1, 1, A0));
        vecs.push_back(mk(1, 2'b01, 2'b01, 2'b00, 0, 1, 2'b10, 2'b01, 1, 1, 0, A0));
        vecs.push_back(mk(1, 2'b01, 2'b00, 2'b00, 0, 1, 2'b10, 2'b01, 1, 0, 0, A0));
        vecs.push_back(mk(1, 2'b00, 2'b00, 2'b00, 0, 0, 2'b11, 2'b00, 0, 0, 0, A0));
        vecs.push_back(mk(1, 2'b00, 2'b00, 2'b00, 0, 0, 2'b11, 2'b00, 0, 0, 0, A0));
        // Round robin from reset
        vecs.push_back(mk(0, 2'b00, 2'b00, 2'b00, 0, 0, 2'b11, 2'b00, 0, 0, 0, A0));
        vecs.push_back(mk(1, 2'b11, 2'b00, 2'b00, 0, 0, 2'b11, 2'b00, 0, 0, 0, A0));
        vecs.push_back(mk(1, 2'b11, 2'b11, 2'b00, 0, 0, 2'b10, 2'b00, 1, 1, 0, A0));
        vecs.push_back(mk(1, 2'b11, 2'b00, 2'b00, 0, 1, 2'b10, 2'b01, 1, 0, 0, A0));
        vecs.push_back(mk(1, 2'b10, 2'b00, 2'b00, 0, 0, 2'b11, 2'b00, 0, 0, 0, A0));
        vecs.push_back(mk(1, 2'b10, 2'b00, 2'b00, 0, 0, 2'b11, 2'b00, 0, 0, 0, A0));
        vecs.push_back(mk(1, 2'b10, 2'b10, 2'b00, 0, 0, 2'b01, 2'b00, 1, 1, 0, A1));
        vecs.push_back(mk(1, 2'b10, 2'b00, 2'b00, 0, 1, 2'b01, 2'b10, 1, 0, 0, A1));
        vecs.push_back(mk(1, 2'b00, 2'b00, 2'b00, 0, 0, 2'b11, 2'b00, 0, 0, 0, A0));
        vecs.push_back(mk(1, 2'b11, 2'b00, 2'b00, 0, 0, 2'b11, 2'b00, 0, 0, 0, A0));
        vecs.push_back(mk(1, 2'b11, 2'b00, 2'b00, 0, 0, 2'b10, 2'b00, 1, 0, 0, A0));
        vecs.push_back(mk(1, 2'b00, 2'b00, 2'b00, 0, 0, 2'b11, 2'b00, 0, 0, 0, A0));
        vecs.push_back(mk(1, 2'b00, 2'b00, 2'b00, 0, 0, 2'b11, 2'b00, 0, 0, 0, A0));
        // Outstanding limit of 2, same-cycle release, ack at zero, controller stall
        vecs.push_back(mk(1, 2'b01, 2'b01, 2'b00, 0, 0, 2'b11, 2'b00, 0, 0, 0, A0));
        vecs.push_back(mk(1, 2'b01, 2'b01, 2'b00, 0, 0, 2'b10, 2'b00, 1, 1, 0, A0));
        vecs.push_back(mk(1, 2'b01, 2'b01, 2'b00, 0, 0, 2'b10, 2'b00, 1, 1, 0, A0));
        vecs.push_back(mk(1, 2'b01, 2'b01, 2'b00, 0, 0, 2'b11, 2'b00, 1, 0, 0, A0));
        vecs.push_back(mk(1, 2'b01, 2'b01, 2'b00, 0, 1, 2'b10, 2'b01, 1, 1, 0, A0));
        vecs.push_back(mk(1, 2'b01, 2'b00, 2'b00, 0, 1, 2'b10, 2'b01, 1, 0, 0, A0));
        vecs.push_back(mk(1, 2'b01, 2'b00, 2'b00, 0, 1, 2'b10, 2'b01, 1, 0, 0, A0));
        vecs.push_back(mk(1, 2'b01, 2'b00, 2'b00, 0, 1, 2'b10, 2'b00, 1, 0, 0, A0));
        vecs.push_back(mk(1, 2'b01, 2'b01, 2'b00, 1, 0, 2'b11, 2'b00, 1, 1, 0, A0));
        vecs.push_back(mk(1, 2'b01, 2'b01, 2'b00, 0, 0, 2'b10, 2'b00, 1, 1, 0, A0));
        vecs.push_back(mk(1, 2'b01, 2'b01, 2'b00, 0, 0, 2'b10, 2'b00, 1, 1, 0, A0));
        // Owner abandons with requests outstanding; late acks dropped, count restarts at 0
        vecs.push_back(mk(1, 2'b00, 2'b00, 2'b00, 0, 1, 2'b11, 2'b00, 0, 0, 0, A0));
        vecs.push_back(mk(1, 2'b00, 2'b00, 2'b00, 0, 1, 2'b11, 2'b00, 0, 0, 0, A0));
        vecs.push_back(mk(1, 2'b00, 2'b00, 2'b00, 0, 1, 2'b11, 2'b00, 0, 0, 0, A0));
        vecs.push_back(mk(1, 2'b01, 2'b01, 2'b00, 0, 0, 2'b11, 2'b00, 0, 0, 0, A0));
        vecs.push_back(mk(1, 2'b01, 2'b01, 2'b00, 0, 0, 2'b10, 2'b00, 1, 1, 0, A0));
        vecs.push_back(mk(1, 2'b01, 2'b01, 2'b00, 0, 0, 2'b10, 2'b00, 1, 1, 0, A0));
        vecs.push_back(mk(1, 2'b01, 2'b01, 2'b00, 0, 0, 2'b11, 2'b00, 1, 0, 0, A0));
        // Asynchronous reset with 2 outstanding, then a fresh grant
        vecs.push_back(mk(0, 2'b01, 2'b01, 2'b00, 0, 0, 2'b11, 2'b00, 0, 0, 0, A0));
        vecs.push_back(mk(1, 2'b00, 2'b00, 2'b00, 0, 1, 2'b11, 2'b00, 0, 0, 0, A0));
        vecs.push_back(mk(1, 2'b01, 2'b01, 2'b00, 0, 1, 2'b11, 2'b00, 0, 0, 0, A0));
        vecs.push_back(mk(1, 2'b01, 2'b01, 2'b00, 0, 1, 2'b10, 2'b00, 1, 1, 0, A0));
        vecs.push_back(mk(1, 2'b01, 2'b00, 2'b00, 0, 1, 2'b10, 2'b01, 1, 0, 0, A0));
        vecs.push_back(mk(1, 2'b00, 2'b00, 2'b00, 0, 0, 2'b11, 2'b00, 0, 0, 0, A0));
        vecs.push_back(mk(1, 2'b00, 2'b00, 2'b00, 0, 0, 2'b11, 2'b00, 0, 0, 0, A0));
        // Requester 0 streams while requester 1 waits
        vecs.push_back(mk(1, 2'b01, 2'b01, 2'b00, 0, 0, 2'b11, 2'b00, 0, 0, 0, A0));
        vecs.push_back(mk(1, 2'b11, 2'b01, 2'b00, 0, 0, 2'b10, 2'b00, 1, 1, 0, A0));
        vecs.push_back(mk(1, 2'b11, 2'b01, 2'b00, 0, 1, 2'b10, 2'b01, 1, 1, 0, A0));
        vecs.push_back(mk(1, 2'b11, 2'b01, 2'b00, 0, 1, 2'b10, 2'b01, 1, 1, 0, A0));
        vecs.push_back(mk(1, 2'b11, 2'b01, 2'b00, 0, 0, 2'b10, 2'b00, 1, 1, 0, A0));
`ifdef WB_ARB_BURST_LIMIT_EN
        vecs.push_back(mk(1, 2'b11, 2'b01, 2'b00, 0, 0, 2'b11, 2'b00, 1, 0, 0, A0));
        vecs.push_back(mk(1, 2'b11, 2'b01, 2'b00, 0, 1, 2'b11, 2'b01, 1, 0, 0, A0));
        vecs.push_back(mk(1, 2'b11, 2'b01, 2'b00, 0, 1, 2'b11, 2'b01, 1, 0, 0, A0));
        vecs.push_back(mk(1, 2'b11, 2'b01, 2'b00, 0, 0, 2'b11, 2'b00, 0, 0, 0, A0));
        vecs.push_back(mk(1, 2'b11, 2'b11, 2'b00, 0, 0, 2'b01, 2'b00, 1, 1, 0, A1));
`else
        vecs.push_back(mk(1, 2'b11, 2'b01, 2'b00, 0, 0, 2'b11, 2'b00, 1, 0, 0, A0));
        vecs.push_back(mk(1, 2'b11, 2'b01, 2'b00, 0, 1, 2'b10, 2'b01, 1, 1, 0, A0));
        vecs.push_back(mk(1, 2'b11, 2'b01, 2'b00, 0, 1, 2'b10, 2'b01, 1, 1, 0, A0));
        vecs.push_back(mk(1, 2'b11, 2'b01, 2'b00, 0, 0, 2'b11, 2'b00, 1, 0, 0, A0));
        vecs.push_back(mk(1, 2'b11, 2'b11, 2'b00, 0, 0, 2'b11, 2'b00, 1, 0, 0, A0));
`endif
        vecs.push_back(mk(1, 2'b00, 2'b00, 2'b00, 0, 0, 2'b11, 2'b00, 0, 0, 0, A0));
        vecs.push_back(mk(1, 2'b00, 2'b00, 2'b00, 0, 0, 2'b11, 2'b00, 0, 0, 0, A0));

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            rst_n   = vecs[i].rst_n;
            s_cyc   = vecs[i].cyc;
            s_stb   = vecs[i].stb;
            s_we    = vecs[i].we;
            m_stall = vecs[i].m_stall;
            m_ack   = vecs[i].m_ack;
            #1;
            chk($sformatf("v%0d o_s_stall", i), DW'(s_stall), DW'(vecs[i].e_stall));
            chk($sformatf("v%0d o_s_ack", i), DW'(s_ack), DW'(vecs[i].e_ack));
            chk($sformatf("v%0d o_m_cyc", i), DW'(m_cyc), DW'(vecs[i].e_mcyc));
            chk($sformatf("v%0d o_m_stb", i), DW'(m_stb), DW'(vecs[i].e_mstb));
            if (vecs[i].e_mcyc) begin
                chk($sformatf("v%0d o_m_addr", i), DW'(m_addr), DW'(vecs[i].e_addr));
                chk($sformatf("v%0d o_m_we", i), DW'(m_we), DW'(vecs[i].e_we));
            end
        end

        // Payload mux for requester 1 and read-data broadcast
        @(negedge clk);
        s_cyc = 2'b10;
        s_stb = 2'b00;
        m_ack = 1'b0;
        m_stall = 1'b0;
        @(negedge clk);
        #1;
        chk("r1 o_m_cyc", DW'(m_cyc), DW'(1'b1));
        chk("r1 o_m_data", m_data, D1);
        chk("r1 o_m_sel", DW'(m_sel), DW'(S1));
        chk("o_s_data", s_rdata, MD);
        @(negedge clk);
        s_cyc = 2'b00;
        #1;
        chk("r1 release o_m_cyc", DW'(m_cyc), DW'(1'b0));
        @(negedge clk);
        #1;
        chk("idle o_s_stall", DW'(s_stall), DW'(2'b11));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
